uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart_rx.sv | 100 ++++++++++
 rtl/uart.sv | 110 +++++++++++
 tb/tb_uart.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes rx_i, finds the start bit, samples each bit at its midpoint.
// Exposes its FSM state so the parent and any bound checker can observe it.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       received_o,
  output logic       recv_error_o,
  output logic [7:0] rx_byte_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      DATA_LAST = 3'd7;

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_sync;

  // Idle-high reset value keeps the FSM from seeing a false start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_byte_o    <= '0;
      received_o   <= 1'b0;
      recv_error_o <= 1'b0;
    end else begin
      received_o   <= 1'b0;
      recv_error_o <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            // A line back high at mid start bit is a glitch, not a frame.
            state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == DATA_LAST) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt          <= '0;
            state        <= RX_IDLE;
            received_o   <= 1'b1;
            recv_error_o <= ~rx_sync;
            rx_byte_o    <= shreg;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: transmitter FSM lives here, receive path is the uart_rx instance.
// Handshake: transmit_i is accepted only in the cycle is_transmitting_o is low; otherwise ignored.
module uart #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       tx_o,
  input  logic       transmit_i,
  input  logic [7:0] tx_byte_i,
  output logic       received_o,
  output logic [7:0] rx_byte_o,
  output logic       is_receiving_o,
  output logic       is_transmitting_o,
  output logic       recv_error_o
);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'd7;
  localparam logic [1:0]    RX_IDLE_ENC = 2'd0;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit_idx;
  logic [7:0]    tx_shreg;
  logic [1:0]    rx_state;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .received_o  (received_o),
    .recv_error_o(recv_error_o),
    .rx_byte_o   (rx_byte_o),
    .state_o     (rx_state)
  );

  // Both busy flags come straight from registered state, so they are glitch-free.
  assign is_receiving_o    = (rx_state != RX_IDLE_ENC);
  assign is_transmitting_o = (tx_state != TX_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
      tx_shreg   <= '0;
      tx_o       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_o       <= 1'b1;
          tx_cnt     <= '0;
          tx_bit_idx <= '0;
          if (transmit_i) begin
            tx_shreg <= tx_byte_i;
            tx_o     <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_o     <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit_idx == DATA_LAST) begin
              tx_o     <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_o       <= tx_shreg[0];
              tx_shreg   <= {1'b0, tx_shreg[7:1]};
              tx_bit_idx <= tx_bit_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart at 16 clocks per bit: transmit waveform, receive scoreboard,
// framing error, glitch rejection, loopback with busy transmit, and mid-frame reset.
module tb_uart;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_drv;
  logic       loopback;
  logic       rx_line;
  logic       tx_o;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       received_o;
  logic [7:0] rx_byte_o;
  logic       is_receiving_o;
  logic       is_transmitting_o;
  logic       recv_error_o;

  int n_cmp = 0;
  int n_err = 0;
  int rx_pulses = 0;
  int err_pulses = 0;

  logic [7:0] exp_q[$];
  logic       err_q[$];

  assign rx_line = loopback ? tx_o : rx_drv;

  uart #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rx_i             (rx_line),
    .tx_o             (tx_o),
    .transmit_i       (transmit),
    .tx_byte_i        (tx_byte),
    .received_o       (received_o),
    .rx_byte_o        (rx_byte_o),
    .is_receiving_o   (is_receiving_o),
    .is_transmitting_o(is_transmitting_o),
    .recv_error_o     (recv_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (received_o) rx_pulses <= rx_pulses + 1;
    if (recv_error_o) err_pulses <= err_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_rx(input int budget);
    logic [7:0] eb;
    logic       ee;
    logic       seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (received_o) begin
        seen = 1'b1;
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        eb = exp_q.pop_front();
        ee = err_q.pop_front();
        check("rx_byte", 32'(rx_byte_o), 32'(eb));
        check("rx_error", 32'(recv_error_o), 32'(ee));
        @(negedge clk);
        check("received_one_cycle", 32'(received_o), 0);
        check("error_one_cycle", 32'(recv_error_o), 0);
      end
    end
    check("rx_seen", 32'(seen), 1);
  endtask

  initial begin
    logic [9:0] frame;
    int         p0;
    int         e0;
    int         hi;

    rst = 1'b1;
    rx_drv = 1'b1;
    loopback = 1'b0;
    transmit = 1'b0;
    tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_o", 32'(tx_o), 1);
    check("rst_received", 32'(received_o), 0);
    check("rst_error", 32'(recv_error_o), 0);
    check("rst_is_rx", 32'(is_receiving_o), 0);
    check("rst_is_tx", 32'(is_transmitting_o), 0);
    check("rst_rx_byte", 32'(rx_byte_o), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Transmit 0xA5: start, LSB-first data, stop; each bit checked mid-bit.
    frame = {1'b1, 8'hA5, 1'b0};
    hi = 0;
    transmit = 1'b1;
    tx_byte = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    transmit = 1'b0;
    for (int i = 0; i < 170; i++) begin
      if (i > 0) @(negedge clk);
      if (is_transmitting_o) hi++;
      if (i < 160 && (i % CPB) == 8) check($sformatf("tx_bit%0d", i / CPB), 32'(tx_o), 32'(frame[i / CPB]));
    end
    check("tx_busy_cycles", 32'(hi), 160);
    check("tx_idle_line", 32'(tx_o), 1);

    // Clean receive of 0x3C.
    p0 = rx_pulses;
    e0 = err_pulses;
    exp_q.push_back(8'h3C);
    err_q.push_back(1'b0);
    fork
      drive_rx_frame(8'h3C, 1'b1);
      wait_rx(400);
    join
    repeat (20) @(negedge clk);
    check("rx_3c_pulses", 32'(rx_pulses - p0), 1);
    check("rx_3c_err_pulses", 32'(err_pulses - e0), 0);
    check("rx_3c_held", 32'(rx_byte_o), 32'h3C);

    // Framing error: stop bit driven low.
    p0 = rx_pulses;
    e0 = err_pulses;
    exp_q.push_back(8'h55);
    err_q.push_back(1'b1);
    fork
      drive_rx_frame(8'h55, 1'b0);
      wait_rx(400);
    join
    repeat (40) @(negedge clk);
    check("ferr_pulses", 32'(rx_pulses - p0), 1);
    check("ferr_err_pulses", 32'(err_pulses - e0), 1);
    check("ferr_idle", 32'(is_receiving_o), 0);

    // Glitch: four low cycles must not start a frame.
    p0 = rx_pulses;
    hi = 0;
    @(negedge clk);
    rx_drv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) rx_drv = 1'b1;
      if (is_receiving_o) hi++;
    end
    check("glitch_seen", 32'(hi != 0), 1);
    check("glitch_short", 32'(hi <= 9), 1);
    check("glitch_no_pulse", 32'(rx_pulses - p0), 0);
    check("glitch_idle", 32'(is_receiving_o), 0);

    // Loopback with a second transmit request while busy.
    loopback = 1'b1;
    p0 = rx_pulses;
    exp_q.push_back(8'h81);
    err_q.push_back(1'b0);
    fork
      begin
        @(negedge clk);
        transmit = 1'b1;
        tx_byte = 8'h81;
        @(negedge clk);
        transmit = 1'b0;
        repeat (50) @(negedge clk);
        check("busy_pre", 32'(is_transmitting_o), 1);
        transmit = 1'b1;
        tx_byte = 8'hFF;
        @(negedge clk);
        transmit = 1'b0;
      end
      wait_rx(400);
    join
    repeat (200) @(negedge clk);
    check("loop_pulses", 32'(rx_pulses - p0), 1);
    check("loop_tx_idle", 32'(is_transmitting_o), 0);
    check("loop_rx_byte", 32'(rx_byte_o), 32'h81);

    // Reset during data bit 3 of a transmit, with the receiver mid-frame via loopback.
    p0 = rx_pulses;
    @(negedge clk);
    transmit = 1'b1;
    tx_byte = 8'h00;
    @(posedge clk);
    @(negedge clk);
    transmit = 1'b0;
    repeat (4 * CPB + 8) @(negedge clk);
    check("mid_busy", 32'(is_transmitting_o), 1);
    check("mid_tx_low", 32'(tx_o), 0);
    check("mid_rx_busy", 32'(is_receiving_o), 1);
    rst = 1'b1;
    #1;
    check("arst_tx_o", 32'(tx_o), 1);
    check("arst_is_tx", 32'(is_transmitting_o), 0);
    check("arst_is_rx", 32'(is_receiving_o), 0);
    check("arst_rx_byte", 32'(rx_byte_o), 0);
    @(negedge clk);
    rst = 1'b0;
    loopback = 1'b0;
    repeat (300) @(negedge clk);
    check("arst_no_pulse", 32'(rx_pulses - p0), 0);
    check("arst_tx_idle", 32'(tx_o), 1);
    check("arst_rx_idle", 32'(is_receiving_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
